// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - six-digit hex display sequencer (IDLE/RUN/SHOW); optional HEX0 blink under HEX_DISPLAY_CTRL_BLINK_EN
module hex_display_ctrl #(
  parameter int TICK_DIV   = 1,
  parameter int BLINK_LOG2 = 23
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        result_valid,
  input  logic [3:0]  result_digit,
  input  logic        clear,
  output logic [23:0] hex_nibble,
  output logic [5:0]  hex_show,
  output logic        busy,
  output logic [15:0] lat_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lat_q, lat_d;
  logic [3:0]    digit_q, digit_d;
  logic [23:0]   nibble_q, nibble_d;
  logic [5:0]    show_q, show_d;
  logic          busy_q, busy_d;
  logic          blink_on_d;

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  logic [BLINK_LOG2:0] blink_q, blink_d;

  // Blink counter restarts on SHOW entry so the digit phase comes first
  always_comb begin
    blink_d = '0;
    if (state_d == S_SHOW && state_q == S_SHOW) begin
      blink_d = blink_q + 1'b1;
    end
    blink_on_d = ~blink_d[BLINK_LOG2];
  end
`else
  localparam int unused_blink_log2 = BLINK_LOG2;
  assign blink_on_d = 1'b1;
`endif

  // Next state: clear beats start, start beats result_valid
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    lat_d   = lat_q;
    digit_d = digit_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
      presc_d = '0;
      lat_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (result_valid) begin
            // freeze: this cycle's tick is dropped
            state_d = S_SHOW;
            digit_d = result_digit;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (lat_q != 16'hFFFF) begin
              lat_d = lat_q + 16'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (result_valid) begin
            digit_d = result_digit;
          end
        end
        default: ;
      endcase
    end
  end

  // Output values derived from the next state so they land on the same edge
  always_comb begin
    nibble_d = '0;
    show_d   = '0;
    busy_d   = 1'b0;
    case (state_d)
      S_RUN: begin
        nibble_d = {lat_d, 8'h00};
        show_d   = 6'b111100;
        busy_d   = 1'b1;
      end
      S_SHOW: begin
        nibble_d = {lat_d, 4'h0, digit_d};
        show_d   = {5'b11110, blink_on_d};
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      lat_q    <= '0;
      digit_q  <= '0;
      nibble_q <= '0;
      show_q   <= '0;
      busy_q   <= 1'b0;
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
      blink_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      lat_q    <= lat_d;
      digit_q  <= digit_d;
      nibble_q <= nibble_d;
      show_q   <= show_d;
      busy_q   <= busy_d;
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
      blink_q  <= blink_d;
`endif
    end
  end

  assign hex_nibble = nibble_q;
  assign hex_show   = show_q;
  assign busy       = busy_q;
  assign lat_count  = lat_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        result_valid = 1'b0;
  logic [3:0]  result_digit = 4'h0;
  logic        clear = 1'b0;
  logic [23:0] hex_nibble;
  logic [5:0]  hex_show;
  logic        busy;
  logic [15:0] lat_count;

  int checks = 0;
  int failures = 0;

  hex_display_ctrl #(
    .TICK_DIV   (1),
    .BLINK_LOG2 (3)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .clear        (clear),
    .hex_nibble   (hex_nibble),
    .hex_show     (hex_show),
    .busy         (busy),
    .lat_count    (lat_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic exp_show0;

    tick();
    tick();
    Reset = 1'b0;
    check("rst_nibble", 32'(hex_nibble), 32'h0);
    check("rst_show", 32'(hex_show), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lat", 32'(lat_count), 32'h0);

    // result_valid in IDLE is ignored
    result_valid = 1'b1; result_digit = 4'd7;
    tick();
    result_valid = 1'b0;
    check("idle_rv_show", 32'(hex_show), 32'h0);
    check("idle_rv_nibble", 32'(hex_nibble), 32'h0);
    check("idle_rv_busy", 32'(busy), 32'h0);

    // start, count to 300, then result 4
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_entry_busy", 32'(busy), 32'h1);
    check("run_entry_lat", 32'(lat_count), 32'h0);
    check("run_entry_show", 32'(hex_show), 32'b111100);
    repeat (300) tick();
    check("run_lat300", 32'(lat_count), 32'd300);
    check("run_nib300", 32'(hex_nibble), 32'h012C00);
    result_valid = 1'b1; result_digit = 4'd4;
    tick();
    result_valid = 1'b0;
    check("show_lat_nib", 32'(hex_nibble[23:8]), 32'h012C);
    check("show_digit", 32'(hex_nibble[3:0]), 32'h4);
    check("show_hex1", 32'(hex_nibble[7:4]), 32'h0);
    check("show_show", 32'(hex_show), 32'b111101);
    check("show_busy", 32'(busy), 32'h0);

    // blink pattern of HEX0 while in SHOW (8 on, 8 off with BLINK_LOG2=3)
    for (int i = 0; i < 32; i++) begin
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
      exp_show0 = ((i / 8) % 2) == 0;
`else
      exp_show0 = 1'b1;
`endif
      check($sformatf("blink_%0d", i), 32'(hex_show[0]), 32'(exp_show0));
      check($sformatf("blink_hi_%0d", i), 32'(hex_show[5:1]), 32'b11110);
      tick();
    end
    check("show_lat_frozen", 32'(lat_count), 32'd300);

    // new result in SHOW overwrites digit only
    result_valid = 1'b1; result_digit = 4'd9;
    tick();
    result_valid = 1'b0;
    check("show_rv_digit", 32'(hex_nibble[3:0]), 32'h9);
    check("show_rv_lat", 32'(lat_count), 32'd300);

    // start and result together in RUN: start wins
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("run_lat10", 32'(lat_count), 32'd10);
    start = 1'b1; result_valid = 1'b1; result_digit = 4'd2;
    tick();
    start = 1'b0; result_valid = 1'b0;
    check("both_lat", 32'(lat_count), 32'h0);
    check("both_busy", 32'(busy), 32'h1);
    check("both_show", 32'(hex_show), 32'b111100);
    tick();
    check("both_lat1", 32'(lat_count), 32'h1);

    // result at count 1, then clear with start in SHOW
    result_valid = 1'b1; result_digit = 4'd5;
    tick();
    result_valid = 1'b0;
    check("show2_busy", 32'(busy), 32'h0);
    check("show2_nib", 32'(hex_nibble), 32'h000105);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clr_show", 32'(hex_show), 32'h0);
    check("clr_nib", 32'(hex_nibble), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_lat_hold", 32'(lat_count), 32'h1);

    // Reset mid-RUN at count 50
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("run_lat50", 32'(lat_count), 32'd50);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_nib", 32'(hex_nibble), 32'h0);
    check("mid_rst_show", 32'(hex_show), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_lat", 32'(lat_count), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_lat0", 32'(lat_count), 32'h0);
    tick();
    check("post_rst_lat1", 32'(lat_count), 32'h1);

    // saturation
    repeat (70000) tick();
    check("sat_lat", 32'(lat_count), 32'hFFFF);
    tick();
    check("sat_hold", 32'(lat_count), 32'hFFFF);
    check("sat_nib", 32'(hex_nibble[23:8]), 32'hFFFF);
    check("sat_busy", 32'(busy), 32'h1);

    // clear from RUN keeps lat_count
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_run_busy", 32'(busy), 32'h0);
    check("clr_run_lat", 32'(lat_count), 32'hFFFF);
    check("clr_run_show", 32'(hex_show), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Sequencer for the six seven-segment digits on the MNIST board. It turns the inference engine's start/result events into per-digit nibble and dash-select values for six hex_driver instances. The block shows dashes while idle and a live inference-latency count while the network runs. It then freezes the latency and presents the classified digit.

## Interface
Parameters:
- TICK_DIV, 1: clock cycles per latency-count increment; must be ≥ 1.
- BLINK_LOG2, 23: blink half-period is 2^BLINK_LOG2 cycles; used only when blink is compiled in.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; inference begins.
- result_valid  input  1  one-cycle pulse; result_digit is valid.
- result_digit  input  4  predicted class, 0–9. 10–15 are passed through unchanged.
- clear  input  1  level; return to idle display.
- hex_nibble  output  24  nibble for HEX0 in bits [3:0], up through HEX5 in bits [23:20].
- hex_show  output  6  per-digit hex_driver dash input. 1 shows the nibble; 0 shows '-'.
- busy  output  1  high while in RUN.
- lat_count  output  16  current/frozen latency count.

## Operation
- FSM states are IDLE, RUN and SHOW. Reset drives the FSM to IDLE.
- Priority each cycle, highest first: Reset, clear, start, result_valid.
- IDLE:
  - hex_show = 6'b000000 (all dashes); hex_nibble = 0; busy = 0; lat_count holds.
  - start → RUN.
  - result_valid is ignored.
- RUN:
  - On entry, lat_count = 0 and the prescaler = 0.
  - The prescaler counts 0..TICK_DIV-1. lat_count increments on prescaler wrap and saturates at 16'hFFFF with no wrap-around.
  - HEX5..HEX2 show lat_count[15:0], with HEX5 the most significant nibble. hex_show[5:2] = 1; hex_show[1:0] = 0.
  - result_valid → SHOW. result_digit is latched and lat_count is frozen at its value in that cycle; the increment in that same cycle is suppressed.
  - start → re-enter RUN: counter restarts at 0.
- SHOW:
  - HEX0 = latched digit, hex_show[0] = 1.
  - HEX1 = dash.
  - HEX5..HEX2 = frozen lat_count.
  - start → RUN; clear → IDLE. result_valid overwrites the latched digit without touching lat_count.
- clear in any state → IDLE. lat_count is not zeroed; it holds until the next RUN entry.
- Simultaneous start and result_valid in RUN: start wins, and the result is discarded.
- Reset mid-RUN or mid-SHOW:
  - Next cycle is IDLE with all outputs at their reset values.
  - Latched digit = 0.
  - Prescaler = 0.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N, with one cycle of latency.
- Reset values:
  - hex_nibble = 24'h0, hex_show = 6'h00, busy = 0, lat_count = 16'h0.
  - Blink phase = 0.
- With TICK_DIV = 1, lat_count reads k after k edges in RUN, counting the entry edge as 0.
- With TICK_DIV = D, lat_count increments on every D-th edge after entry.
- busy rises the cycle after start and falls the cycle after result_valid, clear or Reset.
- No combinational path from any input to any output.

## Configuration
- Macro: HEX_DISPLAY_CTRL_BLINK_EN.
- Defined:
  - In SHOW, a free-running BLINK_LOG2+1-bit counter toggles hex_show[0] every 2^BLINK_LOG2 cycles. HEX0 alternates between digit and dash.
  - Counter and phase reset to 0 on SHOW entry, so the digit shows first.
  - Other digits are unaffected.
- Undefined: hex_show[0] stays at 1 for the whole of SHOW, and the blink counter is not instantiated.

## Test plan
- Reset → all outputs 0, FSM IDLE; then result_valid with digit 7 → no change, hex_show stays 6'h00.
- TICK_DIV = 1: start; result_valid with digit 4 exactly 300 cycles later → hex_nibble[23:8] = 16'h012C, hex_nibble[3:0] = 4, hex_show = 6'b111101, busy = 0.
- TICK_DIV = 1, no result for 70000 cycles → lat_count saturates and holds at 16'hFFFF.
- In RUN, start and result_valid in the same cycle → count restarts at 0 and busy stays 1. Later, clear together with start in SHOW → IDLE, all dashes.
- Reset asserted mid-RUN at count 50 → next cycle outputs are 0 and the FSM is IDLE. A subsequent start counts from 0.
- With HEX_DISPLAY_CTRL_BLINK_EN and BLINK_LOG2 = 3: in SHOW, hex_show[0] is 1 for 8 cycles, 0 for 8 cycles, and repeats. Without the macro, it stays 1.
